// File: rtl/clk_enable_pkg.sv
// Shared constants and mode encoding for the clk_enable_multi tick generator.
package clk_enable_pkg;
  localparam int unsigned CNT_W_DEF   = 28;
  localparam int unsigned DEF_DIV_DEF = 10_000_000;
  localparam int unsigned TICK_CNT_W  = 16;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;
endpackage

// File: rtl/clk_enable_ch.sv
// Single tick channel: divisor/mode registers, counter, one-shot busy flag, registered q.
// Optional saturating tick counter when CLKEN_TICK_COUNT_EN is defined.
module clk_enable_ch
  import clk_enable_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             arm,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic             q,
  output logic             busy
`ifdef CLKEN_TICK_COUNT_EN
  , output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_r, div_n;
  logic [CNT_W-1:0] div_eff;
  mode_e            mode, mode_n;
  logic             busy_n, q_n, terminal;

  // A zero divisor behaves as one so the terminal compare never underflows.
  assign div_eff  = (div_r == '0) ? CNT_W'(1) : div_r;
  assign terminal = (cnt == div_eff - CNT_W'(1));

  always_comb begin
    cnt_n  = cnt;
    div_n  = div_r;
    mode_n = mode;
    busy_n = busy;
    q_n    = 1'b0;
    if (wr) begin
      div_n  = cfg_div;
      mode_n = mode_e'(cfg_oneshot);
      cnt_n  = '0;
      busy_n = 1'b0;
    end else if (mode == MODE_PERIODIC) begin
      if (en) begin
        if (terminal) begin
          cnt_n = '0;
          q_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end else if (en) begin
      // Re-arm beats the terminal count: restart without emitting a tick.
      if (arm) begin
        busy_n = 1'b1;
        cnt_n  = '0;
      end else if (busy) begin
        if (terminal) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          q_n    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      div_r <= DEF_DIV;
      mode  <= MODE_PERIODIC;
      busy  <= 1'b0;
      q     <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      div_r <= div_n;
      mode  <= mode_n;
      busy  <= busy_n;
      q     <= q_n;
    end
  end

`ifdef CLKEN_TICK_COUNT_EN
  always_ff @(posedge clk) begin
    if (clr || wr) begin
      tick_cnt <= '0;
    end else if (q_n && (tick_cnt != '1)) begin
      tick_cnt <= tick_cnt + TICK_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/clk_enable_multi.sv
// Multi-channel clock-enable generator: decodes config writes and replicates clk_enable_ch.
// Define CLKEN_TICK_COUNT_EN to add the per-channel tick_cnt bring-up output.
module clk_enable_multi
  import clk_enable_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] arm,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] q,
  output logic [NUM_CH-1:0] busy
`ifdef CLKEN_TICK_COUNT_EN
  , output logic [NUM_CH*TICK_CNT_W-1:0] tick_cnt
`endif
);

  logic [NUM_CH-1:0] wr_stb;

  // Addresses at or beyond NUM_CH match no channel, so such writes are dropped.
  always_comb begin
    wr_stb = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_stb[i] = cfg_wr && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_enable_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEF_DIV))
    ) u_ch (
      .clk         (clk),
      .clr         (clr),
      .en          (en[g]),
      .arm         (arm[g]),
      .wr          (wr_stb[g]),
      .cfg_div     (cfg_div),
      .cfg_oneshot (cfg_oneshot),
      .q           (q[g]),
      .busy        (busy[g])
`ifdef CLKEN_TICK_COUNT_EN
      , .tick_cnt  (tick_cnt[g*TICK_CNT_W +: TICK_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_clk_enable_multi.sv
// Directed self-checking bench for clk_enable_multi (3 channels, 8-bit counters, reset divisor 10).
// Exercises tick_cnt saturation when CLKEN_TICK_COUNT_EN is defined.
module tb_clk_enable_multi;
  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;

  logic           clk = 1'b0;
  logic           clr;
  logic [NCH-1:0] en, arm;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_oneshot;
  logic [NCH-1:0] q, busy;
`ifdef CLKEN_TICK_COUNT_EN
  logic [NCH*16-1:0] tick_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_enable_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(10)) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .arm         (arm),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .q           (q),
    .busy        (busy)
`ifdef CLKEN_TICK_COUNT_EN
    , .tick_cnt  (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CW-1:0] div, input logic os);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_div = div; cfg_oneshot = os;
    tick();
    cfg_wr = 1'b0;
  endtask

  logic [NCH-1:0] gate_en [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
  logic           gate_q  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    clr = 1'b1; en = '0; arm = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
`ifdef CLKEN_TICK_COUNT_EN
    chk("rst_tick_cnt", tick_cnt[31:0], 32'h0);
`endif

    // Default cadence: all channels tick after edges 10 and 20.
    clr = 1'b0; en = 3'b111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("def_cadence_q", 32'(q), (k % 10 == 0) ? 32'h7 : 32'h0);
      chk("def_busy", 32'(busy), 32'h0);
    end

    // ch2 div=4; ch0/1 sit at cnt=1 after the write edge, tick 9 edges later.
    cfg(2'd2, 8'd4, 1'b0);
    chk("wr_edge_q", 32'(q), 32'h0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("div4_q", 32'(q), {29'd0, (j % 4 == 0), (j == 9), (j == 9)});
    end

    // Gating on ch2 with div=3.
    en = 3'b000;
    cfg(2'd2, 8'd3, 1'b0);
    for (int j = 0; j < 9; j++) begin
      en = {gate_en[j][0], 2'b00};
      tick();
      chk("gate_q", 32'(q), {29'd0, gate_q[j], 2'b00});
    end

    // One-shot on ch1, div=5.
    en = 3'b010;
    cfg(2'd1, 8'd5, 1'b1);
    chk("os_idle_busy", 32'(busy), 32'h0);
    arm = 3'b010; tick(); arm = '0;
    chk("os_arm_busy", 32'(busy), 32'h2);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("os_q", 32'(q), (j == 5) ? 32'h2 : 32'h0);
      chk("os_busy", 32'(busy), (j == 5) ? 32'h0 : 32'h2);
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("os_after_q", 32'(q | busy), 32'h0);
    end

    // Re-arm at count 3 restarts the full countdown.
    arm = 3'b010; tick(); arm = '0;
    tick(); tick(); tick();
    arm = 3'b010; tick(); arm = '0;
    chk("rearm_q", 32'(q), 32'h0);
    chk("rearm_busy", 32'(busy), 32'h2);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("rearm_tick_q", 32'(q), (j == 5) ? 32'h2 : 32'h0);
    end

    // Arm on the terminal edge: no tick, still busy.
    arm = 3'b010; tick(); arm = '0;
    for (int j = 0; j < 4; j++) tick();
    arm = 3'b010; tick(); arm = '0;
    chk("arm_term_q", 32'(q), 32'h0);
    chk("arm_term_busy", 32'(busy), 32'h2);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("arm_term_tick_q", 32'(q), (j == 5) ? 32'h2 : 32'h0);
    end

    // div=0 and div=1 on ch0 tick on every enabled edge.
    en = 3'b001;
    cfg(2'd0, 8'd0, 1'b0);
    chk("div0_wr_q", 32'(q), 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("div0_q", 32'(q), 32'h1);
    end
    cfg(2'd0, 8'd1, 1'b0);
    chk("div1_wr_q", 32'(q), 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("div1_q", 32'(q), 32'h1);
    end

    // Config write on ch2's terminal edge suppresses the tick and zeroes cnt.
    en = 3'b100;
    cfg(2'd2, 8'd3, 1'b0);
    tick(); tick();
    cfg(2'd2, 8'd3, 1'b0);
    chk("wr_term_q", 32'(q), 32'h0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("wr_term_cnt0_q", 32'(q), (j == 3) ? 32'h4 : 32'h0);
    end

    // Out-of-range channel: ch0 keeps div=1 periodic, ch2 keeps counting.
    en = 3'b101;
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7; cfg_oneshot = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("bad_ch_q1", 32'(q), 32'h1);
    tick();
    chk("bad_ch_q2", 32'(q), 32'h1);
    tick();
    chk("bad_ch_q3", 32'(q), 32'h5);

    // clr mid-one-shot returns everything to periodic, divisor 10.
    en = 3'b010;
    arm = 3'b010; tick(); arm = '0;
    tick(); tick();
    chk("mid_os_busy", 32'(busy), 32'h2);
    clr = 1'b1; tick();
    chk("clr_os_q", 32'(q), 32'h0);
    chk("clr_os_busy", 32'(busy), 32'h0);
    clr = 1'b0; en = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("post_clr_q", 32'(q), (k == 10) ? 32'h7 : 32'h0);
    end

`ifdef CLKEN_TICK_COUNT_EN
    en = 3'b001;
    cfg(2'd0, 8'd1, 1'b0);
    chk("tc_wr_clear", 32'(tick_cnt[15:0]), 32'h0);
    for (int k = 0; k < 70000; k++) tick();
    chk("tc_saturate", 32'(tick_cnt[15:0]), 32'hFFFF);
    cfg(2'd0, 8'd1, 1'b0);
    chk("tc_cfg_clear", 32'(tick_cnt[15:0]), 32'h0);
    tick();
    chk("tc_first", 32'(tick_cnt[15:0]), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_enable_multi.md
Name: clk_enable_multi

Overview:
- Parametrised multi-channel clock-enable (tick) generator. Successor to the fixed divide-by-10,000,000 enable used by the vending-machine timing and display logic.
- Each channel produces a one-cycle q pulse every DIV enabled clocks.
- Divisor and mode are run-time programmable per channel. Modes are periodic or one-shot, with per-channel gating.
- Sits beside the top-level FSM and feeds timeouts, display refresh and debounce sampling from one shared clk.

Parameters:
- NUM_CH, 4, number of independent tick channels (1..16).
- CNT_W, 28, counter/divisor width in bits.
- DEF_DIV, 10000000, divisor loaded into every channel at reset.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel-select field (derived, not overridden).

Ports:
- clk  in  1  system clock, sole clock domain.
- clr  in  1  reset, synchronous, active-high.
- en  in  NUM_CH  per-channel count enable; counter holds while low.
- arm  in  NUM_CH  per-channel one-shot start pulse; ignored in periodic mode.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_wr.
- cfg_div  in  CNT_W  new divisor.
- cfg_oneshot  in  1  new mode: 0 = periodic, 1 = one-shot.
- q  out  NUM_CH  registered tick, exactly one cycle wide.
- busy  out  NUM_CH  one-shot countdown in progress.

Behaviour:
- Interface: one clock, clk; reset clr is synchronous and active-high. clr sampled high at a rising edge sets every channel as follows:
  - cnt=0, div_r=DEF_DIV, mode=periodic.
  - q=0, busy=0, optional tick counters=0.
- clr has priority over every other input, including mid-countdown; no tick is emitted on the reset edge.
- Effective divisor: div_eff = max(div_r, 1). A divisor of 0 behaves as 1, giving a tick on every enabled edge.
- Periodic mode, on each edge with en=1:
  - If cnt == div_eff-1: cnt<=0, q<=1.
  - Otherwise: cnt<=cnt+1, q<=0.
  - Result: q is high for one cycle after every div_eff enabled edges.
- Periodic mode, en=0: cnt holds, q<=0. Counting resumes from the held value, so enabled cycles accumulate across gaps.
- One-shot mode:
  - An arm pulse with en=1 sets busy<=1 and cnt<=0.
  - While busy and en=1, counting proceeds as in periodic mode.
  - At the terminal count: q<=1, busy<=0, cnt<=0, and the channel stops.
  - arm while busy restarts from cnt=0 with no tick.
  - arm on the terminal edge: the restart wins, no tick, busy stays 1.
  - Counting is idle while busy=0.
- Config write (cfg_wr=1, cfg_ch < NUM_CH) updates the addressed channel's div_r and mode, clears cnt and busy, and forces q<=0 on that edge.
  - A write coinciding with a terminal count suppresses the tick: the write wins.
  - cfg_ch >= NUM_CH: the write is ignored.
  - Other channels are unaffected.
- Wrap-around: cnt never exceeds div_eff-1. If div_r is lowered below the current cnt, the write-clear rule applies, so no overflow path exists.
- Latency: q is registered, so there is zero combinational path from any input to q.
- Backward compatibility: NUM_CH=1, default parameters, en=1 gives one q pulse every 10,000,000 clocks after reset.

Optional Feature:
- Macro: CLKEN_TICK_COUNT_EN.
- Defined:
  - Adds output tick_cnt, NUM_CH*16 bits (channel i at bits [16i+15:16i]).
  - Each field increments on every q pulse of its channel and saturates at 16'hFFFF.
  - Fields are cleared by clr and by a config write to that channel.
  - Intended for bring-up and coverage.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_enable_pkg holds:
  - the CNT_W default and DEF_DIV constant;
  - the mode typedef (MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1);
  - the TICK_CNT_W=16 constant.
- Sub-module clk_enable_ch is a single channel: counter, div_r, mode, busy, q, and optional tick counter.
  - The top level decodes cfg_ch into per-channel write strobes and instantiates NUM_CH copies with a generate loop.

Test Plan:
- Reset sequence: clr high for 2 cycles, then low. Check q=0 and busy=0 throughout reset. With NUM_CH=1, DEF_DIV=10 and en=1, first q pulse after 10 edges, then every 10 edges, each pulse one cycle wide.
- Write ch2 div=4 periodic, en[2]=1 -> q[2] high after edges 4, 8, 12. Other channels keep DEF_DIV cadence.
- Gating: en toggled 1,0,0,1,… with div=3 -> q only after the 3rd enabled edge; cnt holds while en=0.
- One-shot: write ch1 div=5 oneshot, pulse arm[1] -> busy high 5 cycles, single q pulse, no further ticks. Re-arm at count 3 -> tick arrives 5 edges after the re-arm.
- Boundaries:
  - div=0 and div=1 -> q high every enabled cycle.
  - cfg_wr on a channel's terminal edge -> no tick, cnt=0.
  - cfg_ch=NUM_CH -> no state change.
  - clr asserted mid-one-shot -> busy=0, q=0, div back to DEF_DIV.
- With CLKEN_TICK_COUNT_EN: div=1 for 70000 cycles -> tick_cnt saturates at 65535. Config write clears it to 0.
